// File: rtl/rf_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package rf_writeback_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int STARVE_W   = 3;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = 5'h0;
    localparam logic [STARVE_W-1:0]   STARVE_LIMIT = 3'd4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xdata_t;

    // Content of the single RF write port as it leaves this stage.
    typedef struct packed {
        logic      wen;
        reg_addr_t wa;
        xdata_t    wd;
    } rf_write_t;

    // x0 is hardwired to zero: it is never written and never tracked as pending.
    function automatic logic is_real_dest(input reg_addr_t wa);
        return (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Bundle of the ALU, LTU, issue and RF write-port signals around the writeback stage.
interface rf_writeback_if;
    import rf_writeback_pkg::*;

    logic      alu_valid;
    reg_addr_t alu_wa;
    xdata_t    alu_wd;
    logic      alu_hold;

    logic      ltu_valid;
    reg_addr_t ltu_wa;
    xdata_t    ltu_wd;
    logic      ltu_ready;

    logic      iss_valid;
    logic      iss_long;
    reg_addr_t iss_wa;
    reg_addr_t iss_ra1;
    reg_addr_t iss_ra2;
    logic      iss_stall;

    logic      rf_wen;
    reg_addr_t rf_wa;
    xdata_t    rf_wd;

    // Writeback stage side.
    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        output alu_hold,
        input  ltu_valid, ltu_wa, ltu_wd,
        output ltu_ready,
        input  iss_valid, iss_long, iss_wa, iss_ra1, iss_ra2,
        output iss_stall,
        output rf_wen, rf_wa, rf_wd
    );

    // Pipeline / environment side.
    modport master (
        output alu_valid, alu_wa, alu_wd,
        input  alu_hold,
        output ltu_valid, ltu_wa, ltu_wd,
        input  ltu_ready,
        output iss_valid, iss_long, iss_wa, iss_ra1, iss_ra2,
        input  iss_stall,
        input  rf_wen, rf_wa, rf_wd
    );

endinterface

// File: rtl/rf_writeback_scoreboard.sv
// Pending-write scoreboard for long-latency destinations with a three-port hazard lookup.
module rf_scoreboard
    import rf_writeback_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      iss_valid,
    input  logic      iss_long,
    input  reg_addr_t iss_wa,
    input  reg_addr_t iss_ra1,
    input  reg_addr_t iss_ra2,
    input  logic      clr_en,
    input  reg_addr_t clr_wa,
    output logic      stall
);

    localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_next_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                stall_s;
    logic                set_en_s;

    // Hazard lookup uses only the registered vector, so a same-cycle clear releases next cycle.
    always_comb begin
        stall_s = iss_valid & (pending_r[iss_ra1] | pending_r[iss_ra2] | pending_r[iss_wa]);
    end

    // Set on accepted long issue, clear on LTU acceptance; bit 0 is never tracked.
    always_comb begin
        set_en_s       = iss_valid & iss_long & ~stall_s & is_real_dest(iss_wa);
        set_mask_s     = set_en_s ? (ONE_HOT_0 << iss_wa) : {NUM_REGS{1'b0}};
        clr_mask_s     = (clr_en & is_real_dest(clr_wa)) ? (ONE_HOT_0 << clr_wa) : {NUM_REGS{1'b0}};
        pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
        pending_next_s[0] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign stall = stall_s;

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: ALU/LTU arbitration onto the single RF write port, LTU starvation
// protection, and issue hazard stall via the pending-write scoreboard.
module rf_writeback
    import rf_writeback_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    rf_writeback_if.slave bus
);

    logic                ltu_accept_s;
    logic                stall_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_next_s;
    logic                hold_r;
    rf_write_t           wr_r;
    rf_write_t           wr_next_s;

    // The ALU cannot be back-pressured, so it always wins; the LTU takes any idle slot.
    assign bus.ltu_ready = ~bus.alu_valid;
    assign ltu_accept_s  = bus.ltu_valid & ~bus.alu_valid;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (bus.iss_valid),
        .iss_long  (bus.iss_long),
        .iss_wa    (bus.iss_wa),
        .iss_ra1   (bus.iss_ra1),
        .iss_ra2   (bus.iss_ra2),
        .clr_en    (ltu_accept_s),
        .clr_wa    (bus.ltu_wa),
        .stall     (stall_s)
    );

    // Count consecutive cycles a waiting LTU result loses arbitration, saturating at the limit.
    always_comb begin
        if (bus.ltu_valid && !ltu_accept_s) begin
            starve_next_s = (starve_cnt_r == STARVE_LIMIT) ? starve_cnt_r : (starve_cnt_r + 3'd1);
        end else begin
            starve_next_s = {STARVE_W{1'b0}};
        end
    end

    // Select the winner for the write register; x0 completes the handshake without a write.
    always_comb begin
        wr_next_s     = wr_r;
        wr_next_s.wen = 1'b0;
        case ({bus.alu_valid, ltu_accept_s})
            2'b10: begin
                wr_next_s.wen = is_real_dest(bus.alu_wa);
                if (is_real_dest(bus.alu_wa)) begin
                    wr_next_s.wa = bus.alu_wa;
                    wr_next_s.wd = bus.alu_wd;
                end else begin
                    wr_next_s.wa = wr_r.wa;
                    wr_next_s.wd = wr_r.wd;
                end
            end
            2'b01: begin
                wr_next_s.wen = is_real_dest(bus.ltu_wa);
                if (is_real_dest(bus.ltu_wa)) begin
                    wr_next_s.wa = bus.ltu_wa;
                    wr_next_s.wd = bus.ltu_wd;
                end else begin
                    wr_next_s.wa = wr_r.wa;
                    wr_next_s.wd = wr_r.wd;
                end
            end
            default: begin
                wr_next_s.wen = 1'b0;
            end
        endcase
    end

    // Write-port register, starvation counter and registered ALU hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_r         <= '{wen: 1'b0, wa: ZERO_REG, wd: {XLEN{1'b0}}};
            starve_cnt_r <= {STARVE_W{1'b0}};
            hold_r       <= 1'b0;
        end else begin
            wr_r         <= wr_next_s;
            starve_cnt_r <= starve_next_s;
            hold_r       <= (starve_next_s == STARVE_LIMIT);
        end
    end

    assign bus.alu_hold  = hold_r;
    assign bus.iss_stall = stall_s;
    assign bus.rf_wen    = wr_r.wen;
    assign bus.rf_wa     = wr_r.wa;
    assign bus.rf_wd     = wr_r.wd;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model of the writeback rules.
module tb_rf_writeback;
    import rf_writeback_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rf_writeback_if bus();

    rf_writeback dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          pend [32];
    int          lost;
    bit          m_wen;
    bit          m_hold;
    bit          m_ltu_acc;
    bit          m_iss_acc;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        lost      = 0;
        m_wen     = 1'b0;
        m_hold    = 1'b0;
        m_wa      = 5'd0;
        m_wd      = 32'd0;
        m_ltu_acc = 1'b0;
        m_iss_acc = 1'b0;
    endfunction

    // Compare process: check outputs against the model, then advance the model by one cycle.
    always @(negedge clk) begin : compare
        bit e_stall;
        bit ltu_win;
        if (!reset_n) begin
            model_reset();
            chk("rst_wen", {31'd0, bus.rf_wen}, 32'd0);
            chk("rst_hold", {31'd0, bus.alu_hold}, 32'd0);
            chk("rst_stall", {31'd0, bus.iss_stall}, 32'd0);
        end else begin
            e_stall = bus.iss_valid && (pend[bus.iss_ra1] || pend[bus.iss_ra2] || pend[bus.iss_wa]);
            chk("ltu_ready", {31'd0, bus.ltu_ready}, {31'd0, !bus.alu_valid});
            chk("iss_stall", {31'd0, bus.iss_stall}, {31'd0, e_stall});
            chk("rf_wen", {31'd0, bus.rf_wen}, {31'd0, m_wen});
            chk("alu_hold", {31'd0, bus.alu_hold}, {31'd0, m_hold});
            if (m_wen) begin
                chk("rf_wa", {27'd0, bus.rf_wa}, {27'd0, m_wa});
                chk("rf_wd", bus.rf_wd, m_wd);
            end
            ltu_win = bus.ltu_valid && !bus.alu_valid;
            if (bus.alu_valid) begin
                m_wen = (bus.alu_wa != 5'd0);
                if (m_wen) begin
                    m_wa = bus.alu_wa;
                    m_wd = bus.alu_wd;
                end
            end else if (ltu_win) begin
                m_wen = (bus.ltu_wa != 5'd0);
                if (m_wen) begin
                    m_wa = bus.ltu_wa;
                    m_wd = bus.ltu_wd;
                end
            end else begin
                m_wen = 1'b0;
            end
            if (bus.ltu_valid && !ltu_win) lost = lost + 1;
            else lost = 0;
            m_hold = (lost >= 4);
            if (ltu_win && bus.ltu_wa != 5'd0) pend[bus.ltu_wa] = 1'b0;
            m_iss_acc = bus.iss_valid && !e_stall;
            if (m_iss_acc && bus.iss_long && bus.iss_wa != 5'd0) pend[bus.iss_wa] = 1'b1;
            m_ltu_acc = ltu_win;
        end
    end

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_wa = 5'd0; bus.alu_wd = 32'd0;
        bus.ltu_valid = 1'b0; bus.ltu_wa = 5'd0; bus.ltu_wd = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_long = 1'b0;
        bus.iss_wa = 5'd0; bus.iss_ra1 = 5'd0; bus.iss_ra2 = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n, input int alu_pct, input int iss_pct);
        for (int c = 0; c < n; c++) begin
            step();
            if (m_iss_acc && bus.iss_long) q.push_back(int'(bus.iss_wa));
            bus.alu_valid = !m_hold && ($urandom_range(0, 99) < alu_pct);
            bus.alu_wa    = 5'($urandom_range(0, 31));
            bus.alu_wd    = $urandom;
            if (!(bus.ltu_valid && !m_ltu_acc)) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    bus.ltu_valid = 1'b1;
                    bus.ltu_wa    = 5'(q.pop_front());
                    bus.ltu_wd    = $urandom;
                end else begin
                    bus.ltu_valid = 1'b0;
                end
            end
            bus.iss_valid = ($urandom_range(0, 99) < iss_pct);
            bus.iss_long  = 1'($urandom_range(0, 1));
            bus.iss_wa    = 5'($urandom_range(0, 15));
            bus.iss_ra1   = 5'($urandom_range(0, 15));
            bus.iss_ra2   = 5'($urandom_range(0, 15));
        end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #3;
        chk("init_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("init_wa", {27'd0, bus.rf_wa}, 32'd0);
        chk("init_wd", bus.rf_wd, 32'd0);
        chk("init_hold", {31'd0, bus.alu_hold}, 32'd0);
        chk("init_ready", {31'd0, bus.ltu_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // ALU only
        step(); idle();
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 32'hDEADBEEF;
        step(); idle();
        @(negedge clk);
        chk("alu_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("alu_wa", {27'd0, bus.rf_wa}, 32'd5);
        chk("alu_wd", bus.rf_wd, 32'hDEADBEEF);

        // Collision: ALU first, LTU held and written the next cycle
        step(); idle();
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd3; bus.alu_wd = 32'hA5A50003;
        bus.ltu_valid = 1'b1; bus.ltu_wa = 5'd7; bus.ltu_wd = 32'h00000777;
        @(negedge clk);
        chk("col_ready0", {31'd0, bus.ltu_ready}, 32'd0);
        step(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("col_alu_wa", {27'd0, bus.rf_wa}, 32'd3);
        chk("col_alu_wd", bus.rf_wd, 32'hA5A50003);
        chk("col_ready1", {31'd0, bus.ltu_ready}, 32'd1);
        step(); idle();
        @(negedge clk);
        chk("col_ltu_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("col_ltu_wa", {27'd0, bus.rf_wa}, 32'd7);
        step();
        @(negedge clk);
        chk("keep_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("keep_wa", {27'd0, bus.rf_wa}, 32'd7);
        chk("keep_wd", bus.rf_wd, 32'h00000777);

        // RAW hazard on a long-latency destination
        step(); idle();
        bus.iss_valid = 1'b1; bus.iss_long = 1'b1; bus.iss_wa = 5'd9;
        @(negedge clk);
        chk("haz_issue", {31'd0, bus.iss_stall}, 32'd0);
        step(); idle();
        bus.iss_valid = 1'b1; bus.iss_ra1 = 5'd9; bus.iss_wa = 5'd1;
        bus.ltu_valid = 1'b1; bus.ltu_wa = 5'd9; bus.ltu_wd = 32'h99;
        @(negedge clk);
        chk("haz_stall", {31'd0, bus.iss_stall}, 32'd1);
        step(); bus.ltu_valid = 1'b0;
        @(negedge clk);
        chk("haz_release", {31'd0, bus.iss_stall}, 32'd0);
        chk("haz_wa", {27'd0, bus.rf_wa}, 32'd9);

        // Starvation: four lost cycles raise hold
        for (int k = 0; k < 4; k++) begin
            step(); idle();
            bus.ltu_valid = 1'b1; bus.ltu_wa = 5'd12; bus.ltu_wd = 32'h0C0C0C0C;
            bus.alu_valid = 1'b1; bus.alu_wa = 5'd20; bus.alu_wd = 32'(k);
            @(negedge clk);
            chk("starve_hold0", {31'd0, bus.alu_hold}, 32'd0);
        end
        step(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("starve_hold1", {31'd0, bus.alu_hold}, 32'd1);
        chk("starve_ready", {31'd0, bus.ltu_ready}, 32'd1);
        step(); idle();
        @(negedge clk);
        chk("starve_drop", {31'd0, bus.alu_hold}, 32'd0);
        chk("starve_wa", {27'd0, bus.rf_wa}, 32'd12);

        // x0 destination: handshake without write, never pending
        step(); idle();
        bus.ltu_valid = 1'b1; bus.ltu_wa = 5'd0; bus.ltu_wd = 32'h1234;
        @(negedge clk);
        chk("x0_ready", {31'd0, bus.ltu_ready}, 32'd1);
        step(); idle();
        bus.iss_valid = 1'b1; bus.iss_long = 1'b1; bus.iss_wa = 5'd0;
        @(negedge clk);
        chk("x0_wen", {31'd0, bus.rf_wen}, 32'd0);
        step();
        @(negedge clk);
        chk("x0_nostall", {31'd0, bus.iss_stall}, 32'd0);

        // Reset in the middle of a write with a live hazard
        step(); idle();
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 32'h1;
        bus.iss_valid = 1'b1; bus.iss_long = 1'b1; bus.iss_wa = 5'd9;
        step(); idle();
        bus.iss_valid = 1'b1; bus.iss_ra1 = 5'd9; bus.iss_wa = 5'd2;
        @(negedge clk);
        chk("mid_wen", {31'd0, bus.rf_wen}, 32'd1);
        chk("mid_stall", {31'd0, bus.iss_stall}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("async_hold", {31'd0, bus.alu_hold}, 32'd0);
        chk("async_stall", {31'd0, bus.iss_stall}, 32'd0);
        idle();
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic: mixed load, ALU-heavy starvation pressure, then drain
        run_random(400, 40, 60);
        run_random(200, 95, 60);
        run_random(100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
